mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 SHALL have parameter MAX_HOLD, default 8 (legal range 2..255), giving the maximum number of cycles one grant is held.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req  input  4  request from each of four sources sharing the 4:1 mux; bit i selects mux input Ii.
REQ-005 SHALL have port done  input  1  current owner finished; releases the grant.
REQ-006 SHALL have port gnt  output  4  registered one-hot grant; all-zero when idle.
REQ-007 SHALL have port sel  output  2  registered mux select (sel[1]=S1, sel[0]=S0) equal to the binary index of the owner.
REQ-008 SHALL have port busy  output  1  registered; high while any gnt bit is high.
REQ-009 SHALL have port timeout  output  1  registered one-cycle pulse when a grant is force-released at MAX_HOLD.

Function
REQ-010 SHALL implement two states: IDLE (no owner) and GRANT (one owner).
REQ-011 SHALL keep an internal 2-bit round-robin pointer ptr and a hold counter of $clog2(MAX_HOLD+1) bits.
REQ-012 Arbitration SHALL pick the first asserted req bit searching ptr, ptr+1, ... mod 4 (3 wraps to 0).
REQ-013 In IDLE with req==0, state, gnt, sel, busy SHALL hold; sel keeps the last owner index so the mux input stays stable.
REQ-014 In IDLE with req!=0, the next edge SHALL enter GRANT with gnt, sel, busy updated to the winner; req-to-gnt latency is exactly 1 cycle.
REQ-015 In GRANT, the hold counter SHALL start at 1 on the first grant cycle and increment each cycle the grant is held.
REQ-016 Release SHALL occur on the edge where any of: done==1; req[owner]==0; hold counter == MAX_HOLD.
REQ-017 On release, ptr SHALL become owner+1 mod 4.
REQ-018 On release with any req bit asserted, arbitration (REQ-012, using the updated ptr) SHALL grant the winner on the same edge with no idle gap; the previous owner wins only if it is the sole requester.
REQ-019 On release with req==0, the FSM SHALL return to IDLE: gnt=0, busy=0, sel unchanged.
REQ-020 timeout SHALL pulse high for exactly one cycle, coincident with the first cycle after a release caused solely by the hold limit; done==1 or req[owner]==0 on the same edge takes priority and suppresses timeout.
REQ-021 Requests from non-owners SHALL NOT disturb the current grant before release.
REQ-022 gnt SHALL never have more than one bit set, and sel SHALL always equal the index of the set gnt bit when busy==1.
REQ-023 done asserted while in IDLE SHALL be ignored.

Reset
REQ-024 Asserting rst SHALL immediately, without clk, force state=IDLE, gnt=0000, sel=00, busy=0, timeout=0, ptr=0, hold counter=0.
REQ-025 rst asserted mid-grant SHALL drop the grant immediately; after deassertion, the first arbitration SHALL start from ptr=0.

Verification
REQ-026 Reset, then req=0101 -> one edge later gnt=0001, sel=00, busy=1; done pulse -> gnt=0100, sel=10 on the next edge, no idle cycle.
REQ-027 req=1111 held, done pulsed every 2nd cycle -> grant order 0,1,2,3,0 with sel 00,01,10,11,00.
REQ-028 MAX_HOLD=8, req=0010 held, done=0 -> gnt=0010 for 8 cycles, timeout pulses once, requester 1 regranted with counter restarted.
REQ-029 MAX_HOLD=8, req=1010 held, done=0 -> owner 1 for 8 cycles, timeout pulse, owner 3 (sel=11) for the next 8 cycles.
REQ-030 Owner 2 granted and req drops to 0000 -> next edge gnt=0000, busy=0, sel stays 10; done and the hold limit on the same edge -> no timeout pulse.
REQ-031 rst raised asynchronously mid-grant (gnt=1000) -> all outputs zero before the next clk edge; after release with req=1001 -> gnt=0001.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter for four sources sharing a 4:1 mux. Grants are held until done,
// request drop, or the MAX_HOLD cycle limit, and then passed on with no idle gap.
module mux4_rr_arbiter #(
    parameter int unsigned MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       busy,
    output logic       timeout
);

    localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
    localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);

    typedef enum logic {StIdle, StGrant} state_e;

    state_e           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic             busy_q, busy_d;
    logic             timeout_q, timeout_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [HoldW-1:0] hold_q, hold_d;

    logic       owner_req;
    logic       at_limit;
    logic       release_now;
    logic [1:0] next_ptr;
    logic [1:0] arb_base;
    logic [1:0] win;

    // Scan from the highest offset down so the closest requester to start wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] start, input logic [3:0] r);
        logic [1:0] idx;
        rr_pick = start;
        for (int i = 3; i >= 0; i--) begin
            idx = start + 2'(i);
            if (r[idx]) rr_pick = idx;
        end
    endfunction

    assign owner_req   = req[sel_q];
    assign at_limit    = (hold_q == HoldMax);
    assign release_now = done | ~owner_req | at_limit;
    assign next_ptr    = sel_q + 2'd1;
    // On release the pointer update and the re-arbitration happen on the same edge.
    assign arb_base    = (state_q == StGrant) ? next_ptr : ptr_q;
    assign win         = rr_pick(arb_base, req);

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        sel_d     = sel_q;
        busy_d    = busy_q;
        timeout_d = 1'b0;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        case (state_q)
            StIdle: begin
                if (|req) begin
                    state_d = StGrant;
                    gnt_d   = 4'b0001 << win;
                    sel_d   = win;
                    busy_d  = 1'b1;
                    hold_d  = HoldW'(1);
                end
            end
            StGrant: begin
                if (release_now) begin
                    ptr_d     = next_ptr;
                    timeout_d = at_limit & ~done & owner_req;
                    if (|req) begin
                        gnt_d  = 4'b0001 << win;
                        sel_d  = win;
                        busy_d = 1'b1;
                        hold_d = HoldW'(1);
                    end else begin
                        state_d = StIdle;
                        gnt_d   = 4'b0000;
                        busy_d  = 1'b0;
                        hold_d  = '0;
                    end
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            gnt_q     <= 4'b0000;
            sel_q     <= 2'b00;
            busy_q    <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= 2'b00;
            hold_q    <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            sel_q     <= sel_d;
            busy_q    <= busy_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
        end
    end

    assign gnt     = gnt_q;
    assign sel     = sel_q;
    assign busy    = busy_q;
    assign timeout = timeout_q;

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed bench for mux4_rr_arbiter: expected outputs are queued as each step is
// driven and popped for comparison one cycle later.
module tb_mux4_rr_arbiter;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;

    int checks = 0;
    int passes = 0;

    typedef struct packed {
        logic [3:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       timeout;
    } exp_t;

    exp_t  exp_q[$];
    string tag_q[$];

    mux4_rr_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .done    (done),
        .gnt     (gnt),
        .sel     (sel),
        .busy    (busy),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input exp_t e);
        chk({tag, ".gnt"}, gnt, e.gnt);
        chk({tag, ".sel"}, {2'b00, sel}, {2'b00, e.sel});
        chk({tag, ".busy"}, {3'b000, busy}, {3'b000, e.busy});
        chk({tag, ".timeout"}, {3'b000, timeout}, {3'b000, e.timeout});
    endtask

    // Drive inputs, queue the expected post-edge outputs, then compare after the edge.
    task automatic step(input logic [3:0] r, input logic d, input logic [3:0] eg,
                        input logic [1:0] es, input logic eb, input logic et,
                        input string tag);
        exp_t e;
        req  = r;
        done = d;
        exp_q.push_back(exp_t'{gnt: eg, sel: es, busy: eb, timeout: et});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check_all(tag_q.pop_front(), e);
    endtask

    // Raise reset between edges and confirm outputs clear before the next clock.
    task automatic async_reset(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check_all(tag, exp_t'{gnt: 4'b0000, sel: 2'b00, busy: 1'b0, timeout: 1'b0});
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst  = 1'b1;
        req  = 4'b0000;
        done = 1'b0;
        #7;
        check_all("reset", exp_t'{gnt: 4'b0000, sel: 2'b00, busy: 1'b0, timeout: 1'b0});
        #1;
        rst = 1'b0;

        // First grant and hand-off on done with no idle cycle.
        step(4'b0101, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t1_grant0");
        step(4'b0101, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0, "t1_handoff2");
        // Owner 2 drops its request: idle, sel keeps last owner.
        step(4'b0000, 1'b0, 4'b0000, 2'b10, 1'b0, 1'b0, "t1_drop_idle");
        step(4'b0000, 1'b1, 4'b0000, 2'b10, 1'b0, 1'b0, "t1_done_in_idle");

        // Full rotation with done every second cycle.
        async_reset("t2_reset");
        step(4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t2_g0a");
        step(4'b1111, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t2_g0b");
        step(4'b1111, 1'b1, 4'b0010, 2'b01, 1'b1, 1'b0, "t2_g1a");
        step(4'b1111, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "t2_g1b");
        step(4'b1111, 1'b1, 4'b0100, 2'b10, 1'b1, 1'b0, "t2_g2a");
        step(4'b1111, 1'b0, 4'b0100, 2'b10, 1'b1, 1'b0, "t2_g2b");
        step(4'b1111, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, "t2_g3a");
        step(4'b1111, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, "t2_g3b");
        step(4'b1111, 1'b1, 4'b0001, 2'b00, 1'b1, 1'b0, "t2_g0_wrap");
        step(4'b0000, 1'b0, 4'b0000, 2'b00, 1'b0, 1'b0, "t2_idle");

        // Sole requester hits the hold limit and is re-granted.
        step(4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "t3_hold1");
        for (int i = 2; i <= 8; i++)
            step(4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, $sformatf("t3_hold%0d", i));
        step(4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b1, "t3_timeout_regrant");
        step(4'b0010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "t3_pulse_end");
        step(4'b0000, 1'b0, 4'b0000, 2'b01, 1'b0, 1'b0, "t3_idle");

        // Two requesters alternate on the hold limit.
        async_reset("t4_reset");
        step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, "t4_own1_hold1");
        for (int i = 2; i <= 8; i++)
            step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, $sformatf("t4_own1_hold%0d", i));
        step(4'b1010, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b1, "t4_own3_timeout");
        for (int i = 2; i <= 8; i++)
            step(4'b1010, 1'b0, 4'b1000, 2'b11, 1'b1, 1'b0, $sformatf("t4_own3_hold%0d", i));
        step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b1, "t4_own1_timeout");

        // done coincides with the hold limit: release without a timeout pulse.
        for (int i = 2; i <= 8; i++)
            step(4'b1010, 1'b0, 4'b0010, 2'b01, 1'b1, 1'b0, $sformatf("t5_hold%0d", i));
        step(4'b1010, 1'b1, 4'b1000, 2'b11, 1'b1, 1'b0, "t5_done_at_limit");

        // Asynchronous reset mid-grant, then arbitration restarts from source 0.
        async_reset("t6_midgrant_reset");
        step(4'b1001, 1'b0, 4'b0001, 2'b00, 1'b1, 1'b0, "t6_after_reset");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
